// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset/run-control sequencer: state encodings,
// default timing constants and width helpers.
package rst_sequencer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_HOLD    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2,
    S_END     = 2'd3
  } state_t;

  localparam int DEF_N_DOMAINS   = 2;
  localparam int DEF_HOLD_CYCLES = 25;
  localparam int DEF_STAGGER     = 4;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TIMEOUT     = 0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..limit with one bit of headroom.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1) + 1;
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Run-control bundle between the sequencer and whoever drives/observes it.
interface rst_sequencer_if #(
  parameter int N_DOMAINS = 2,
  parameter int CNT_W     = 32
);
  import rst_sequencer_pkg::*;

  logic                 sw_rst_req;
  logic                 halt_i;
  logic [N_DOMAINS-1:0] dom_rst_o;
  logic                 rdy_o;
  logic [CNT_W-1:0]     cycle_cnt_o;
  logic                 done_o;
  logic                 timeout_o;
  logic [STATE_W-1:0]   state_o;

  modport slave (
    input  sw_rst_req, halt_i,
    output dom_rst_o, rdy_o, cycle_cnt_o, done_o, timeout_o, state_o
  );

  modport master (
    output sw_rst_req, halt_i,
    input  dom_rst_o, rdy_o, cycle_cnt_o, done_o, timeout_o, state_o
  );

endinterface

// File: rtl/rst_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rst_sequencer.sv
// Holds all downstream domains in reset, releases them one by one, then counts
// run cycles until halt or watchdog expiry. Re-triggerable via sw_rst_req.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int N_DOMAINS   = DEF_N_DOMAINS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  rst_sequencer_if.slave  ctl
);

  localparam int SEQ_W = cnt_width(imax(HOLD_CYCLES, STAGGER));
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

  localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYCLES - 1);
  localparam logic [SEQ_W-1:0] STAG_LAST = SEQ_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [CMP_W-1:0] TO_LAST   = CMP_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               FAST_REL  = (N_DOMAINS == 1) || (STAGGER == 0);

  state_t               state_q, state_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d, dom_shift;
  logic                 rdy_q, rdy_d;
  logic                 done_q, done_d;
  logic                 to_q, to_d;

  logic                 seq_clr, seq_en;
  logic                 run_clr, run_en;
  logic [SEQ_W-1:0]     seq_cnt;
  logic [CNT_W-1:0]     run_cnt;
  logic                 to_hit;

  sat_counter #(.W(SEQ_W)) u_seq_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (seq_clr),
    .en_i    (seq_en),
    .count_o (seq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (run_clr),
    .en_i    (run_en),
    .count_o (run_cnt)
  );

  // Domains release LSB first: shifting zeros in clears the next bit in line.
  assign dom_shift = dom_q << 1;

  // The increment about to happen lands on TIMEOUT; a saturated counter never does.
  assign to_hit = (TIMEOUT != 0) && (run_cnt != '1) && (CMP_W'(run_cnt) == TO_LAST);

  always_comb begin
    state_d = state_q;
    dom_d   = dom_q;
    rdy_d   = rdy_q;
    done_d  = done_q;
    to_d    = to_q;
    seq_clr = 1'b0;
    seq_en  = 1'b0;
    run_clr = 1'b0;
    run_en  = 1'b0;

    if (ctl.sw_rst_req) begin
      state_d = S_HOLD;
      dom_d   = '1;
      rdy_d   = 1'b0;
      done_d  = 1'b0;
      to_d    = 1'b0;
      seq_clr = 1'b1;
      run_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (seq_cnt == HOLD_LAST) begin
            seq_clr = 1'b1;
            if (FAST_REL) begin
              dom_d   = '0;
              rdy_d   = 1'b1;
              state_d = S_RUN;
            end else begin
              dom_d   = dom_shift;
              state_d = S_STAGGER;
            end
          end else begin
            seq_en = 1'b1;
          end
        end
        S_STAGGER: begin
          if (seq_cnt == STAG_LAST) begin
            seq_clr = 1'b1;
            dom_d   = dom_shift;
            if (dom_shift == '0) begin
              rdy_d   = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            seq_en = 1'b1;
          end
        end
        S_RUN: begin
          if (ctl.halt_i) begin
            done_d  = 1'b1;
            state_d = S_END;
          end else begin
            run_en = 1'b1;
            if (to_hit) begin
              to_d    = 1'b1;
              state_d = S_END;
            end
          end
        end
        S_END: begin
          state_d = S_END;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HOLD;
      dom_q   <= '1;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign ctl.dom_rst_o   = dom_q;
  assign ctl.rdy_o       = rdy_q;
  assign ctl.cycle_cnt_o = run_cnt;
  assign ctl.done_o      = done_q;
  assign ctl.timeout_o   = to_q;
  assign ctl.state_o     = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: three configurations side by side, each tracked by a
// timeline model (cycles since sequence start -> expected outputs).
module tb_rst_sequencer;
  import rst_sequencer_pkg::*;

  logic clk;
  logic rstv [3];
  logic sw   [3];
  logic halt [3];

  int checks = 0;
  int errors = 0;

  // Configurations: 0 = defaults, 1 = defaults + TIMEOUT 50, 2 = 4 domains fast / 4-bit counter
  int PN [3] = '{DEF_N_DOMAINS, DEF_N_DOMAINS, 4};
  int PH [3] = '{DEF_HOLD_CYCLES, DEF_HOLD_CYCLES, 1};
  int PS [3] = '{DEF_STAGGER, DEF_STAGGER, 0};
  int PW [3] = '{32, 32, 4};
  int PT [3] = '{0, 50, 0};

  int     mt    [3];
  longint mcnt  [3];
  bit     mdone [3];
  bit     mto   [3];
  bit     mend  [3];

  rst_sequencer_if #(.N_DOMAINS(2), .CNT_W(32)) if0 ();
  rst_sequencer_if #(.N_DOMAINS(2), .CNT_W(32)) if1 ();
  rst_sequencer_if #(.N_DOMAINS(4), .CNT_W(4))  if2 ();

  assign if0.sw_rst_req = sw[0];
  assign if0.halt_i     = halt[0];
  assign if1.sw_rst_req = sw[1];
  assign if1.halt_i     = halt[1];
  assign if2.sw_rst_req = sw[2];
  assign if2.halt_i     = halt[2];

  rst_sequencer #(.N_DOMAINS(2), .HOLD_CYCLES(DEF_HOLD_CYCLES), .STAGGER(DEF_STAGGER),
                  .CNT_W(32), .TIMEOUT(0))
    dut0 (.clk(clk), .rst(rstv[0]), .ctl(if0.slave));
  rst_sequencer #(.N_DOMAINS(2), .HOLD_CYCLES(DEF_HOLD_CYCLES), .STAGGER(DEF_STAGGER),
                  .CNT_W(32), .TIMEOUT(50))
    dut1 (.clk(clk), .rst(rstv[1]), .ctl(if1.slave));
  rst_sequencer #(.N_DOMAINS(4), .HOLD_CYCLES(1), .STAGGER(0), .CNT_W(4), .TIMEOUT(0))
    dut2 (.clk(clk), .rst(rstv[2]), .ctl(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset(int k);
    mt[k] = 0; mcnt[k] = 0; mdone[k] = 0; mto[k] = 0; mend[k] = 0;
  endfunction

  function automatic int last_release(int k);
    int es;
    es = (PN[k] == 1) ? 0 : PS[k];
    return PH[k] + (PN[k] - 1) * es;
  endfunction

  function automatic void model_step(int k, bit s, bit h);
    longint cmax;
    cmax = (longint'(1) << PW[k]) - 1;
    if (s) begin
      model_reset(k);
      return;
    end
    if (mt[k] >= last_release(k) && !mend[k]) begin
      if (h) begin
        mdone[k] = 1; mend[k] = 1;
      end else begin
        if (mcnt[k] < cmax) mcnt[k] = mcnt[k] + 1;
        if (PT[k] != 0 && mcnt[k] == PT[k]) begin
          mto[k] = 1; mend[k] = 1;
        end
      end
    end
    if (mt[k] < 1000000) mt[k] = mt[k] + 1;
  endfunction

  function automatic logic [44:0] exp_vec(int k);
    logic [7:0] d;
    logic [1:0] st;
    logic       r;
    int es, last;
    es   = (PN[k] == 1) ? 0 : PS[k];
    last = last_release(k);
    d = '0;
    for (int i = 0; i < PN[k]; i++) d[i] = (mt[k] < PH[k] + i * es);
    r  = (mt[k] >= last);
    st = mend[k] ? 2'd3 : (mt[k] >= last) ? 2'd2 : (mt[k] >= PH[k]) ? 2'd1 : 2'd0;
    return {d, r, 32'(mcnt[k]), mdone[k], mto[k], st};
  endfunction

  function automatic logic [44:0] act_vec(int k);
    case (k)
      0:       return {8'(if0.dom_rst_o), if0.rdy_o, 32'(if0.cycle_cnt_o), if0.done_o, if0.timeout_o, if0.state_o};
      1:       return {8'(if1.dom_rst_o), if1.rdy_o, 32'(if1.cycle_cnt_o), if1.done_o, if1.timeout_o, if1.state_o};
      default: return {8'(if2.dom_rst_o), if2.rdy_o, 32'(if2.cycle_cnt_o), if2.done_o, if2.timeout_o, if2.state_o};
    endcase
  endfunction

  // Advance one clock with the current inputs, keep the model in step.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rstv[k]) model_reset(k);
      else         model_step(k, sw[k], halt[k]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rstv[k] = 1'b1; sw[k] = 1'b0; halt[k] = 1'b0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_vec(k) !== exp_vec(k)) begin
        errors++;
        $display("FAIL reset dut%0d: got %h expected %h", k, act_vec(k), exp_vec(k));
      end
    end
    checks++;
    if (if2.dom_rst_o !== 4'hF || if2.rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_dom dut2: got dom=%h rdy=%b expected dom=f rdy=0", if2.dom_rst_o, if2.rdy_o);
    end
    for (int k = 0; k < 3; k++) rstv[k] = 1'b0;
  endtask

  task automatic test_startup();
    int guard;
    for (int c = 1; c <= 30; c++) begin
      halt[0] = (mt[0] < last_release(0)) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL startup dut%0d cyc %0d: got %h expected %h", k, c, act_vec(k), exp_vec(k));
        end
      end
      if (c == 1) begin
        checks++;
        if (if2.dom_rst_o !== 4'h0 || if2.rdy_o !== 1'b1) begin
          errors++;
          $display("FAIL fast_release dut2: got dom=%h rdy=%b expected dom=0 rdy=1", if2.dom_rst_o, if2.rdy_o);
        end
      end
      if (c == 24 || c == 25 || c == 29) begin
        checks++;
        if (if0.dom_rst_o !== ((c == 24) ? 2'b11 : (c == 25) ? 2'b10 : 2'b00) ||
            if0.rdy_o !== (c == 29)) begin
          errors++;
          $display("FAIL release_timing cyc %0d: got dom=%b rdy=%b", c, if0.dom_rst_o, if0.rdy_o);
        end
      end
      if (c == 30) begin
        checks++;
        if (if0.cycle_cnt_o !== 32'd1) begin
          errors++;
          $display("FAIL first_count: got %0d expected 1", if0.cycle_cnt_o);
        end
      end
    end
    halt[0] = 1'b0;
    guard = 0;
    while (if0.cycle_cnt_o !== 32'd100 && guard < 200) begin
      tick();
      guard++;
      checks++;
      if (act_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL run dut0: got %h expected %h", act_vec(0), exp_vec(0));
      end
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL reach_100: got %0d expected 100 within 200 cycles", if0.cycle_cnt_o);
    end
    halt[0] = 1'b1;
    tick();
    halt[0] = 1'b0;
    checks++;
    if (if0.done_o !== 1'b1 || if0.cycle_cnt_o !== 32'd100 || if0.state_o !== 2'd3 || if0.timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL halt: got done=%b cnt=%0d st=%0d to=%b expected 1 100 3 0",
               if0.done_o, if0.cycle_cnt_o, if0.state_o, if0.timeout_o);
    end
    for (int c = 0; c < 20; c++) begin
      halt[0] = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (act_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL end_hold dut0: got %h expected %h", act_vec(0), exp_vec(0));
      end
    end
    halt[0] = 1'b0;
    checks++;
    if (if0.cycle_cnt_o !== 32'd100 || if0.rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL end_frozen: got cnt=%0d rdy=%b expected 100 1", if0.cycle_cnt_o, if0.rdy_o);
    end
  endtask

  task automatic test_sw_rst();
    sw[0] = 1'b1;
    tick();
    sw[0] = 1'b0;
    checks++;
    if (if0.dom_rst_o !== 2'b11 || if0.done_o !== 1'b0 || if0.cycle_cnt_o !== 32'd0 ||
        if0.rdy_o !== 1'b0 || if0.state_o !== 2'd0) begin
      errors++;
      $display("FAIL sw_rst: got dom=%b done=%b cnt=%0d rdy=%b st=%0d expected 11 0 0 0 0",
               if0.dom_rst_o, if0.done_o, if0.cycle_cnt_o, if0.rdy_o, if0.state_o);
    end
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (act_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL replay cyc %0d: got %h expected %h", c, act_vec(0), exp_vec(0));
      end
      if (c == 25 || c == 29) begin
        checks++;
        if (if0.dom_rst_o !== ((c == 25) ? 2'b10 : 2'b00)) begin
          errors++;
          $display("FAIL replay_release cyc %0d: got %b", c, if0.dom_rst_o);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int guard;
    sw[1] = 1'b1;
    tick();
    sw[1] = 1'b0;
    guard = 0;
    while (if1.timeout_o !== 1'b1 && guard < 200) begin
      tick();
      guard++;
      checks++;
      if (act_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL timeout_run: got %h expected %h", act_vec(1), exp_vec(1));
      end
    end
    checks++;
    if (if1.timeout_o !== 1'b1 || if1.done_o !== 1'b0 || if1.cycle_cnt_o !== 32'd50 || if1.state_o !== 2'd3) begin
      errors++;
      $display("FAIL timeout: got to=%b done=%b cnt=%0d st=%0d expected 1 0 50 3",
               if1.timeout_o, if1.done_o, if1.cycle_cnt_o, if1.state_o);
    end
    sw[1] = 1'b1;
    tick();
    sw[1] = 1'b0;
    guard = 0;
    while (if1.cycle_cnt_o !== 32'd49 && guard < 200) begin
      tick();
      guard++;
    end
    halt[1] = 1'b1;
    tick();
    halt[1] = 1'b0;
    checks++;
    if (if1.done_o !== 1'b1 || if1.timeout_o !== 1'b0 || if1.cycle_cnt_o !== 32'd49) begin
      errors++;
      $display("FAIL halt_vs_timeout: got done=%b to=%b cnt=%0d expected 1 0 49",
               if1.done_o, if1.timeout_o, if1.cycle_cnt_o);
    end
    checks++;
    if (act_vec(1) !== exp_vec(1)) begin
      errors++;
      $display("FAIL halt_vs_timeout_model: got %h expected %h", act_vec(1), exp_vec(1));
    end
  endtask

  task automatic test_narrow();
    sw[2] = 1'b1;
    tick();
    sw[2] = 1'b0;
    checks++;
    if (if2.dom_rst_o !== 4'hF || if2.rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL narrow_hold: got dom=%h rdy=%b expected f 0", if2.dom_rst_o, if2.rdy_o);
    end
    tick();
    checks++;
    if (if2.dom_rst_o !== 4'h0 || if2.rdy_o !== 1'b1 || if2.state_o !== 2'd2) begin
      errors++;
      $display("FAIL narrow_release: got dom=%h rdy=%b st=%0d expected 0 1 2", if2.dom_rst_o, if2.rdy_o, if2.state_o);
    end
    for (int c = 0; c < 22; c++) begin
      tick();
      checks++;
      if (act_vec(2) !== exp_vec(2)) begin
        errors++;
        $display("FAIL narrow_run: got %h expected %h", act_vec(2), exp_vec(2));
      end
    end
    checks++;
    if (if2.cycle_cnt_o !== 4'd15 || if2.state_o !== 2'd2) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d st=%0d expected 15 2", if2.cycle_cnt_o, if2.state_o);
    end
  endtask

  task automatic test_async_rst();
    sw[0] = 1'b1;
    tick();
    sw[0] = 1'b0;
    repeat (27) tick();
    #3;
    rstv[0] = 1'b1;
    #1;
    checks++;
    if (if0.dom_rst_o !== 2'b11 || if0.rdy_o !== 1'b0 || if0.cycle_cnt_o !== 32'd0 ||
        if0.state_o !== 2'd0 || if0.done_o !== 1'b0 || if0.timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got dom=%b rdy=%b cnt=%0d st=%0d expected 11 0 0 0",
               if0.dom_rst_o, if0.rdy_o, if0.cycle_cnt_o, if0.state_o);
    end
    model_reset(0);
    #2;
    rstv[0] = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      tick();
      checks++;
      if (act_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL after_async cyc %0d: got %h expected %h", c, act_vec(0), exp_vec(0));
      end
      if (c == 25 || c == 29) begin
        checks++;
        if (if0.dom_rst_o !== ((c == 25) ? 2'b10 : 2'b00)) begin
          errors++;
          $display("FAIL after_async_release cyc %0d: got %b", c, if0.dom_rst_o);
        end
      end
    end
  endtask

  task automatic test_random();
    int burst [3];
    for (int k = 0; k < 3; k++) burst[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (burst[k] == 0 && $urandom_range(0, 99) < 2) burst[k] = $urandom_range(1, 4);
        sw[k]   = (burst[k] > 0);
        if (burst[k] > 0) burst[k]--;
        halt[k] = ($urandom_range(0, 39) == 0);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d: got %h expected %h", k, c, act_vec(k), exp_vec(k));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      sw[k] = 1'b0; halt[k] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstv[k] = 1'b1; sw[k] = 1'b0; halt[k] = 1'b0;
      model_reset(k);
    end
    test_reset();
    test_startup();
    test_sw_rst();
    test_timeout();
    test_narrow();
    test_async_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
